nl_traffic_sink: RTL and testbench

- Per-node packet sink at one mesh network ejection port, instantiated once per (x,y) node.
- Consumes every flit delivered by the network and returns one credit per flit.
- Reassembles packets per exit VC; classifies them as warmup, measurement or dropped.
- Accumulates latency/hop statistics for measurement packets only; the top level sums them across nodes.

---
 rtl/nl_traffic_sink_pkg.sv | 67 ++++++
 rtl/nl_traffic_sink_vc_tracker.sv | 69 ++++++
 rtl/nl_traffic_sink.sv | 190 +++++++++++++++++++
 tb/tb_nl_traffic_sink.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nl_traffic_sink_pkg.sv
// Shared network types: flit, credit channel and simulation statistics records,
// plus coordinate and min/max helpers used by the sink (and by source/network).
package nl_traffic_sink_pkg;

    localparam int XDIM          = 4;
    localparam int YDIM          = 4;
    localparam int NVX           = 2;
    localparam int X_W           = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int Y_W           = (YDIM > 1) ? $clog2(YDIM) : 1;
    localparam int VC_W          = (NVX > 1) ? $clog2(NVX) : 1;
    localparam int HOP_W         = 8;
    localparam int MAX_HOPS      = XDIM + YDIM;
    localparam int LAT_FREQ_LAST = 1000;
    localparam int LAT_BIN_MAX   = 100;
    localparam logic [31:0] MIN_INIT = 32'h7FFF_FFFF;

    typedef logic [X_W-1:0]   x_coord_t;
    typedef logic [Y_W-1:0]   y_coord_t;
    typedef logic [HOP_W-1:0] hop_t;

    typedef struct packed {
        logic            valid;
        logic            head;
        logic            tail;
        logic [VC_W-1:0] vc_id;
        x_coord_t        src_x;
        y_coord_t        src_y;
        x_coord_t        dst_x;
        y_coord_t        dst_y;
        logic [31:0]     inject_time;
        hop_t            hops;
    } flit_t;

    typedef struct packed {
        logic            credit_valid;
        logic [VC_W-1:0] credit_vc;
    } chan_cntrl_t;

    typedef struct packed {
        logic [31:0]                     total_latency;
        logic [31:0]                     total_hops;
        logic [31:0]                     min_latency;
        logic [31:0]                     max_latency;
        logic [31:0]                     min_hops;
        logic [31:0]                     max_hops;
        logic [MAX_HOPS:0][31:0]         total_lat_for_hop_count;
        logic [MAX_HOPS:0][31:0]         total_packets_with_hop_count;
        logic [LAT_FREQ_LAST:0][31:0]    lat_freq;
    } sim_stats_t;

    function automatic x_coord_t set_x_cur(input int pos);
        return x_coord_t'(pos);
    endfunction

    function automatic y_coord_t set_y_cur(input int pos);
        return y_coord_t'(pos);
    endfunction

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nl_traffic_sink_vc_tracker.sv
// Per-VC packet reassembly: latches the head payload, tracks the bad flag and
// flags completion when this VC's tail flit is accepted.
module nl_sink_vc_tracker
    import nl_traffic_sink_pkg::*;
#(
    parameter int vc_index = 0,
    parameter int xpos     = 0,
    parameter int ypos     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic            head,
    input  logic            tail,
    input  logic [VC_W-1:0] vc_id,
    input  x_coord_t        dst_x,
    input  y_coord_t        dst_y,
    input  logic [31:0]     inject_time,
    input  hop_t            hops,
    output logic            done,
    output logic            bad,
    output logic [31:0]     pkt_inject_time,
    output hop_t            pkt_hops
);

    logic        in_packet_reg;
    logic        bad_reg;
    logic [31:0] inject_reg;
    hop_t        hops_reg;
    logic        hit;
    logic        dst_ok;

    assign hit    = valid && (vc_id == VC_W'(vc_index));
    assign dst_ok = (dst_x == set_x_cur(xpos)) && (dst_y == set_y_cur(ypos));
    assign done   = hit && tail;

    // A head restarts the packet; anything else inherits the latched state and
    // is bad if no head opened the packet.
    always_comb begin
        bad             = bad_reg || !in_packet_reg;
        pkt_inject_time = inject_reg;
        pkt_hops        = hops_reg;
        if (hit && head) begin
            bad             = !dst_ok || in_packet_reg;
            pkt_inject_time = inject_time;
            pkt_hops        = hops;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_packet_reg <= 1'b0;
            bad_reg       <= 1'b0;
            inject_reg    <= '0;
            hops_reg      <= '0;
        end else if (hit) begin
            if (tail) begin
                in_packet_reg <= 1'b0;
                bad_reg       <= 1'b0;
            end else begin
                in_packet_reg <= 1'b1;
                bad_reg       <= bad;
                inject_reg    <= pkt_inject_time;
                hops_reg      <= pkt_hops;
            end
        end
    end

endmodule

// File: rtl/nl_traffic_sink.sv
// Ejection-port packet sink: returns a credit per flit, reassembles packets per
// VC and accumulates latency/hop statistics for the measurement window.
module nl_traffic_sink
    import nl_traffic_sink_pkg::*;
#(
    parameter int xdim                   = 4,
    parameter int ydim                   = 4,
    parameter int xpos                   = 0,
    parameter int ypos                   = 0,
    parameter int warmup_packets         = 100,
    parameter int measurement_packets    = 1000,
    parameter int router_num_vcs_on_exit = NVX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  flit_t       flit_in,
    output chan_cntrl_t cntrl_out,
    output logic [31:0] rec_count,
    output logic [31:0] rec_count_dropped,
    output sim_stats_t  stats
);

    localparam int NV        = router_num_vcs_on_exit;
    localparam int HOP_CLAMP = (xdim + ydim < MAX_HOPS) ? (xdim + ydim) : MAX_HOPS;
    localparam int HB_W      = $clog2(MAX_HOPS + 1);
    localparam int BIN_W     = $clog2(LAT_BIN_MAX + 1);

    logic [31:0] cycle_reg;
    logic [31:0] warmup_reg;
    logic [31:0] rec_count_reg;
    logic [31:0] dropped_reg;
    logic [31:0] total_latency_reg;
    logic [31:0] total_hops_reg;
    logic [31:0] min_latency_reg;
    logic [31:0] max_latency_reg;
    logic [31:0] min_hops_reg;
    logic [31:0] max_hops_reg;
    logic [31:0] lat_freq_reg    [LAT_BIN_MAX+1];
    logic [31:0] hop_lat_reg     [MAX_HOPS+1];
    logic [31:0] hop_pkts_reg    [MAX_HOPS+1];

    logic [NV-1:0] done_vec;
    logic [NV-1:0] bad_vec;
    logic [31:0]   vc_inject [NV];
    hop_t          vc_hops   [NV];

    logic             cmp_done;
    logic             cmp_bad;
    logic [31:0]      cmp_inject;
    hop_t             cmp_hops;
    logic [31:0]      latency;
    logic [BIN_W-1:0] lat_bin;
    logic [HB_W-1:0]  hop_bin;
    logic             warm_inc;
    logic             record;
    logic [X_W+Y_W+X_W+Y_W-1:0] src_unused;

    // Source coordinates travel with the flit but play no part in sink accounting.
    assign src_unused = {flit_in.src_x, flit_in.src_y, flit_in.src_x, flit_in.src_y};

    genvar gi;
    generate
        for (gi = 0; gi < NV; gi++) begin : g_vc
            nl_sink_vc_tracker #(
                .vc_index (gi),
                .xpos     (xpos),
                .ypos     (ypos)
            ) u_vc_tracker (
                .clk             (clk),
                .rst_n           (rst_n),
                .valid           (flit_in.valid),
                .head            (flit_in.head),
                .tail            (flit_in.tail),
                .vc_id           (flit_in.vc_id),
                .dst_x           (flit_in.dst_x),
                .dst_y           (flit_in.dst_y),
                .inject_time     (flit_in.inject_time),
                .hops            (flit_in.hops),
                .done            (done_vec[gi]),
                .bad             (bad_vec[gi]),
                .pkt_inject_time (vc_inject[gi]),
                .pkt_hops        (vc_hops[gi])
            );
        end
    endgenerate

    // Only one tail arrives per cycle, so at most one tracker completes.
    always_comb begin
        cmp_done   = 1'b0;
        cmp_bad    = 1'b0;
        cmp_inject = '0;
        cmp_hops   = '0;
        for (int i = 0; i < NV; i++) begin
            if (done_vec[i]) begin
                cmp_done   = 1'b1;
                cmp_bad    = bad_vec[i];
                cmp_inject = vc_inject[i];
                cmp_hops   = vc_hops[i];
            end
        end
    end

    assign latency  = cycle_reg - cmp_inject;
    assign lat_bin  = (latency > 32'(LAT_BIN_MAX)) ? BIN_W'(LAT_BIN_MAX) : latency[BIN_W-1:0];
    assign hop_bin  = (cmp_hops > HOP_W'(HOP_CLAMP)) ? HB_W'(HOP_CLAMP) : cmp_hops[HB_W-1:0];
    assign warm_inc = cmp_done && !cmp_bad && (warmup_reg < 32'(warmup_packets));
    assign record   = cmp_done && !cmp_bad && (warmup_reg >= 32'(warmup_packets))
                      && (rec_count_reg < 32'(measurement_packets));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_reg         <= '0;
            warmup_reg        <= '0;
            rec_count_reg     <= '0;
            dropped_reg       <= '0;
            total_latency_reg <= '0;
            total_hops_reg    <= '0;
            min_latency_reg   <= MIN_INIT;
            max_latency_reg   <= '0;
            min_hops_reg      <= MIN_INIT;
            max_hops_reg      <= '0;
            cntrl_out         <= '0;
        end else begin
            cycle_reg              <= cycle_reg + 32'd1;
            cntrl_out.credit_valid <= flit_in.valid;
            cntrl_out.credit_vc    <= flit_in.vc_id;
            if (cmp_done && cmp_bad) begin
                dropped_reg <= dropped_reg + 32'd1;
            end
            if (warm_inc) begin
                warmup_reg <= warmup_reg + 32'd1;
            end
            if (record) begin
                rec_count_reg     <= rec_count_reg + 32'd1;
                total_latency_reg <= total_latency_reg + latency;
                total_hops_reg    <= total_hops_reg + 32'(cmp_hops);
                min_latency_reg   <= min32(min_latency_reg, latency);
                max_latency_reg   <= max32(max_latency_reg, latency);
                min_hops_reg      <= min32(min_hops_reg, 32'(cmp_hops));
                max_hops_reg      <= max32(max_hops_reg, 32'(cmp_hops));
            end
        end
    end

    generate
        for (gi = 0; gi <= LAT_BIN_MAX; gi++) begin : g_lat_freq
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lat_freq_reg[gi] <= '0;
                end else if (record && (lat_bin == BIN_W'(gi))) begin
                    lat_freq_reg[gi] <= lat_freq_reg[gi] + 32'd1;
                end
            end
        end

        for (gi = 0; gi <= MAX_HOPS; gi++) begin : g_hop_bins
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hop_lat_reg[gi]  <= '0;
                    hop_pkts_reg[gi] <= '0;
                end else if (record && (hop_bin == HB_W'(gi))) begin
                    hop_lat_reg[gi]  <= hop_lat_reg[gi] + latency;
                    hop_pkts_reg[gi] <= hop_pkts_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign rec_count         = rec_count_reg;
    assign rec_count_dropped = dropped_reg;

    // Latency bins above LAT_BIN_MAX are never written and stay zero.
    always_comb begin
        stats               = '0;
        stats.total_latency = total_latency_reg;
        stats.total_hops    = total_hops_reg;
        stats.min_latency   = min_latency_reg;
        stats.max_latency   = max_latency_reg;
        stats.min_hops      = min_hops_reg;
        stats.max_hops      = max_hops_reg;
        for (int i = 0; i <= LAT_BIN_MAX; i++) begin
            stats.lat_freq[i] = lat_freq_reg[i];
        end
        for (int i = 0; i <= MAX_HOPS; i++) begin
            stats.total_lat_for_hop_count[i]      = hop_lat_reg[i];
            stats.total_packets_with_hop_count[i] = hop_pkts_reg[i];
        end
    end

endmodule

// File: tb/tb_nl_traffic_sink.sv
// Directed bench for nl_traffic_sink: table of back-to-back packet flits plus
// hand sequences for VC interleave, latency clamp, orphan flits and reset.
`timescale 1ns/1ps
module tb_nl_traffic_sink;
    import nl_traffic_sink_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    flit_t       flit_in;
    chan_cntrl_t cntrl_out;
    logic [31:0] rec_count;
    logic [31:0] rec_count_dropped;
    sim_stats_t  stats;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;

    typedef struct {
        logic head;
        logic tail;
        int   vc;
        int   dx;
        int   dy;
        int   hops;
        int   delta;
        int   exp_rc;
        int   exp_drop;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Expected timestamp: zero during reset, +1 per cycle afterwards.
    always @(posedge clk) cyc <= rst_n ? cyc + 32'd1 : 32'd0;

    nl_traffic_sink #(
        .xdim                   (4),
        .ydim                   (4),
        .xpos                   (1),
        .ypos                   (1),
        .warmup_packets         (2),
        .measurement_packets    (3),
        .router_num_vcs_on_exit (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flit_in           (flit_in),
        .cntrl_out         (cntrl_out),
        .rec_count         (rec_count),
        .rec_count_dropped (rec_count_dropped),
        .stats             (stats)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one valid flit; inject_time = current timestamp - delta.
    task automatic send(input logic h, input logic t, input int vc, input int dx,
                        input int dy, input int hops, input int delta);
        @(negedge clk);
        flit_in             = '0;
        flit_in.valid       = 1'b1;
        flit_in.head        = h;
        flit_in.tail        = t;
        flit_in.vc_id       = VC_W'(vc);
        flit_in.dst_x       = x_coord_t'(dx);
        flit_in.dst_y       = y_coord_t'(dy);
        flit_in.inject_time = cyc - 32'(delta);
        flit_in.hops        = hop_t'(hops);
        @(posedge clk);
        #1;
        chk("credit_valid", 32'(cntrl_out.credit_valid), 32'd1);
        chk("credit_vc", 32'(cntrl_out.credit_vc), 32'(vc));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n   = 1'b0;
        flit_in = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   rc_after [6];
        int   rc_prev;
        vec_t v;

        rc_after = '{0, 0, 1, 2, 3, 3};
        flit_in  = '0;

        // Reset with a live flit present: no credit may be returned.
        @(negedge clk);
        rst_n         = 1'b0;
        flit_in.valid = 1'b1;
        flit_in.head  = 1'b1;
        flit_in.tail  = 1'b1;
        flit_in.dst_x = x_coord_t'(1);
        flit_in.dst_y = y_coord_t'(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rec_count", rec_count, 32'd0);
        chk("rst_dropped", rec_count_dropped, 32'd0);
        chk("rst_min_latency", stats.min_latency, 32'h7FFF_FFFF);
        chk("rst_min_hops", stats.min_hops, 32'h7FFF_FFFF);
        chk("rst_max_latency", stats.max_latency, 32'd0);
        chk("rst_credit_valid", 32'(cntrl_out.credit_valid), 32'd0);
        $display("reset: rec_count=%0d dropped=%0d", rec_count, rec_count_dropped);
        @(negedge clk);
        rst_n   = 1'b1;
        flit_in = '0;

        // Six good 4-flit packets (latency 10, hops 3), then one misrouted packet.
        rc_prev = 0;
        for (int p = 0; p < 6; p++) begin
            for (int f = 0; f < 4; f++) begin
                v.head = (f == 0); v.tail = (f == 3); v.vc = 0; v.dx = 1; v.dy = 1;
                v.hops = 3; v.delta = 7;
                v.exp_rc = (f == 3) ? rc_after[p] : rc_prev; v.exp_drop = 0;
                vecs.push_back(v);
            end
            rc_prev = rc_after[p];
        end
        for (int f = 0; f < 4; f++) begin
            v.head = (f == 0); v.tail = (f == 3); v.vc = 0; v.dx = 2; v.dy = 1;
            v.hops = 3; v.delta = 7; v.exp_rc = 3; v.exp_drop = (f == 3) ? 1 : 0;
            vecs.push_back(v);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].head, vecs[i].tail, vecs[i].vc, vecs[i].dx, vecs[i].dy,
                 vecs[i].hops, vecs[i].delta);
            chk($sformatf("vec%0d_rec_count", i), rec_count, 32'(vecs[i].exp_rc));
            chk($sformatf("vec%0d_dropped", i), rec_count_dropped, 32'(vecs[i].exp_drop));
            $display("vec %0d head=%0b tail=%0b vc=%0d dst=(%0d,%0d) rc=%0d drop=%0d",
                     i, vecs[i].head, vecs[i].tail, vecs[i].vc, vecs[i].dx, vecs[i].dy,
                     rec_count, rec_count_dropped);
        end
        chk("tbl_total_latency", stats.total_latency, 32'd30);
        chk("tbl_total_hops", stats.total_hops, 32'd9);
        chk("tbl_pkts_hop3", stats.total_packets_with_hop_count[3], 32'd3);
        chk("tbl_lat_hop3", stats.total_lat_for_hop_count[3], 32'd30);
        chk("tbl_lat_freq10", stats.lat_freq[10], 32'd3);
        chk("tbl_min_latency", stats.min_latency, 32'd10);
        chk("tbl_max_latency", stats.max_latency, 32'd10);
        chk("tbl_min_hops", stats.min_hops, 32'd3);
        chk("tbl_max_hops", stats.max_hops, 32'd3);

        // Fresh session: two warmup packets, then interleaved VC0/VC1 packets.
        do_reset(3);
        chk("rst2_rec_count", rec_count, 32'd0);
        chk("rst2_total_latency", stats.total_latency, 32'd0);
        send(1, 1, 0, 1, 1, 1, 5);
        send(1, 1, 1, 1, 1, 1, 5);
        chk("warm_rec_count", rec_count, 32'd0);
        $display("warmup: rec_count=%0d", rec_count);

        send(1, 0, 0, 1, 1, 2, 14);
        send(1, 0, 1, 1, 1, 4, 9);
        send(0, 0, 0, 0, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0, 0);
        send(0, 0, 1, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0, 0);
        chk("il_rec_count_vc0", rec_count, 32'd1);
        send(0, 1, 1, 0, 0, 0, 0);
        chk("il_rec_count", rec_count, 32'd2);
        chk("il_total_latency", stats.total_latency, 32'd35);
        chk("il_total_hops", stats.total_hops, 32'd6);
        chk("il_min_latency", stats.min_latency, 32'd15);
        chk("il_max_latency", stats.max_latency, 32'd20);
        chk("il_min_hops", stats.min_hops, 32'd2);
        chk("il_max_hops", stats.max_hops, 32'd4);
        chk("il_lat_freq20", stats.lat_freq[20], 32'd1);
        chk("il_lat_freq15", stats.lat_freq[15], 32'd1);
        chk("il_lat_hop4", stats.total_lat_for_hop_count[4], 32'd15);
        chk("il_pkts_hop2", stats.total_packets_with_hop_count[2], 32'd1);
        $display("interleave: rec_count=%0d total_latency=%0d", rec_count, stats.total_latency);

        // Latency 250 with 9 hops: latency bin and hop bin both clamp.
        send(1, 1, 1, 1, 1, 9, 250);
        chk("big_rec_count", rec_count, 32'd3);
        chk("big_lat_freq100", stats.lat_freq[100], 32'd1);
        chk("big_max_latency", stats.max_latency, 32'd250);
        chk("big_total_latency", stats.total_latency, 32'd285);
        chk("big_total_hops", stats.total_hops, 32'd15);
        chk("big_max_hops", stats.max_hops, 32'd9);
        chk("big_pkts_hop8", stats.total_packets_with_hop_count[8], 32'd1);
        chk("big_lat_hop8", stats.total_lat_for_hop_count[8], 32'd250);
        $display("latency250: rec_count=%0d max_latency=%0d", rec_count, stats.max_latency);

        // Beyond the measurement window: consumed, not recorded.
        send(1, 1, 0, 1, 1, 1, 5);
        chk("late_rec_count", rec_count, 32'd3);
        chk("late_total_latency", stats.total_latency, 32'd285);
        chk("late_lat_freq5", stats.lat_freq[5], 32'd0);
        chk("late_min_latency", stats.min_latency, 32'd15);

        // Body then tail with no head: one dropped packet.
        send(0, 0, 0, 1, 1, 1, 5);
        chk("orphan_body_dropped", rec_count_dropped, 32'd0);
        send(0, 1, 0, 1, 1, 1, 5);
        chk("orphan_dropped", rec_count_dropped, 32'd1);
        chk("orphan_rec_count", rec_count, 32'd3);
        $display("orphan: dropped=%0d", rec_count_dropped);

        // Reset in the middle of a packet, then a fresh packet on the same VC.
        do_reset(3);
        send(1, 0, 0, 1, 1, 2, 3);
        send(0, 0, 0, 1, 1, 2, 3);
        do_reset(2);
        send(1, 0, 0, 1, 1, 2, 3);
        send(0, 0, 0, 0, 0, 0, 0);
        send(0, 0, 0, 0, 0, 0, 0);
        send(0, 1, 0, 0, 0, 0, 0);
        chk("mid_dropped", rec_count_dropped, 32'd0);
        chk("mid_rec_count_warm", rec_count, 32'd0);
        send(1, 1, 1, 1, 1, 2, 3);
        send(1, 1, 0, 1, 1, 2, 7);
        chk("mid_rec_count", rec_count, 32'd1);
        chk("mid_total_latency", stats.total_latency, 32'd7);
        chk("mid_min_latency", stats.min_latency, 32'd7);
        chk("mid_lat_freq7", stats.lat_freq[7], 32'd1);
        chk("mid_dropped_end", rec_count_dropped, 32'd0);
        $display("midreset: rec_count=%0d dropped=%0d", rec_count, rec_count_dropped);

        @(negedge clk);
        flit_in = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
